axi_stream_slave_rx: RTL and testbench

AXI4-Stream slave receiver: accepts 32-bit beats from an upstream stream master, buffers data and TLAST in an internal FIFO, and tracks packet boundaries. The downstream reader pulls words through a first-word-fall-through valid/ready port. It sits at the input of the AES datapath and at the receiving end of the stream master testbench models. It also exposes the complete-packet count and sticky protocol-error flags.

---
 rtl/axis_rx_pkg.sv | 24 ++
 rtl/axis_rx_fifo.sv | 75 +++++++
 rtl/axi_stream_slave_rx.sv | 180 ++++++++++++++++++
 tb/tb_axi_stream_slave_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_rx_pkg.sv
// Shared types and constants for the AXI4-Stream receive slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DEF_*          default parameter values used by the top level
//   rx_state_t     receive FSM state (idle between packets / inside a packet)
//   STRB_ALL_ONES  all-ones strobe reference; slice to the active strobe width
package axis_rx_pkg;

    localparam int DEF_TDATA_WIDTH   = 32;
    localparam int DEF_FIFO_DEPTH    = 16;
    localparam int DEF_MAX_PKT_WORDS = 16;

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_PKT  = 1'b1
    } rx_state_t;

    // Wide enough for data buses up to 1024 bits. Users take the low
    // TDATA_WIDTH/8 bits as the "every byte valid" reference.
    localparam logic [127:0] STRB_ALL_ONES = '1;

endpackage

// File: rtl/axis_rx_fifo.sv
// Synchronous first-word-fall-through FIFO, WIDTH bits x DEPTH words.
// Latency: a word written at edge k is visible on rd_dat after edge k (no same-cycle bypass).
// Backpressure: writes are ignored while full; reads are ignored while empty.
//
// Ports:
//   core_clk, rst      clock and asynchronous active-high reset
//   wr_vld, wr_dat     push request and data; stored when !full
//   rd_rdy, rd_dat     pop request and head data; head advances when !empty
//   full, empty        occupancy == DEPTH / occupancy == 0
//   occupancy          number of stored words, 0..DEPTH
module axis_rx_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                       core_clk,
    input  logic                       rst,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic             push;
    logic             pop;

    // Full/empty come straight from the registered occupancy count, so the
    // write-side ready never depends on the incoming valid.
    assign full      = (occ == CW'(DEPTH));
    assign empty     = (occ == '0);
    assign occupancy = occ;

    assign push = wr_vld && !full;
    assign pop  = rd_rdy && !empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: nothing is observable until occupancy says so.
    always_ff @(posedge core_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/axi_stream_slave_rx.sv
// AXI4-Stream slave receiver: buffers beats + TLAST, tracks packets and protocol errors.
// Latency: beat accepted at edge k appears on rd_data/rd_valid after edge k.
// Backpressure: s00_axis_tready drops only when the buffer is full; reader pops at will.
//
// Ports:
//   s00_axis_aclk, s00_axis_areset   clock, asynchronous active-high reset
//   s00_axis_t{valid,data,strb,last} upstream beat; s00_axis_tready accepts it
//   rd_valid, rd_data, rd_last       FWFT head word; rd_ready pops it
//   pkt_count                        packets whose last word is buffered, not yet read
//   rx_busy                          a packet is partially received
//   err_strb, err_len, err_clr       sticky protocol-error flags and their clear
module axi_stream_slave_rx
    import axis_rx_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int FIFO_DEPTH           = DEF_FIFO_DEPTH,
    parameter int MAX_PKT_WORDS        = DEF_MAX_PKT_WORDS
) (
    input  logic                                 s00_axis_aclk,
    input  logic                                 s00_axis_areset,
    input  logic                                 s00_axis_tvalid,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]      s00_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]    s00_axis_tstrb,
    input  logic                                 s00_axis_tlast,
    output logic                                 s00_axis_tready,
    output logic                                 rd_valid,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]      rd_data,
    output logic                                 rd_last,
    input  logic                                 rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      pkt_count,
    output logic                                 rx_busy,
    output logic                                 err_strb,
    output logic                                 err_len,
    input  logic                                 err_clr
);

    localparam int DW     = C_S_AXIS_TDATA_WIDTH;
    localparam int STRB_W = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int PCW    = $clog2(FIFO_DEPTH + 1);
    localparam int BCW    = $clog2(MAX_PKT_WORDS + 1);

    localparam logic [STRB_W-1:0] STRB_FULL = STRB_ALL_ONES[STRB_W-1:0];

    // ------------------------------------------------------------------
    // Buffer: {tlast, tdata} per entry
    // ------------------------------------------------------------------
    logic [DW:0]    fifo_rd_dat;
    logic           fifo_full;
    logic           fifo_empty;
    logic [PCW-1:0] fifo_occ;

    axis_rx_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk  (s00_axis_aclk),
        .rst       (s00_axis_areset),
        .wr_vld    (s00_axis_tvalid),
        .wr_dat    ({s00_axis_tlast, s00_axis_tdata}),
        .rd_rdy    (rd_ready),
        .rd_dat    (fifo_rd_dat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    logic accept;
    logic pop;

    assign s00_axis_tready = !fifo_full;
    assign rd_valid        = !fifo_empty;
    assign rd_data         = fifo_rd_dat[DW-1:0];
    // The stored TLAST of an empty buffer is stale (or unreset) memory;
    // qualify it so rd_last only ever reports a live head word.
    assign rd_last         = rd_valid && fifo_rd_dat[DW];

    assign accept = s00_axis_tvalid && s00_axis_tready;
    assign pop    = rd_valid && rd_ready;

    // ------------------------------------------------------------------
    // Complete-packet count
    // ------------------------------------------------------------------
    logic pkt_inc;
    logic pkt_dec;

    assign pkt_inc = accept && s00_axis_tlast;
    assign pkt_dec = pop && rd_last;

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            pkt_count <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + PCW'(1);
                2'b01:   pkt_count <= pkt_count - PCW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM and beat counter
    // ------------------------------------------------------------------
    // beat_cnt holds the number of beats already accepted for the packet in
    // progress; it stays at zero in RX_IDLE. It saturates at MAX_PKT_WORDS,
    // so every beat past the legal length sees the same "over length" value.
    rx_state_t      state;
    logic [BCW-1:0] beat_cnt;

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state    <= RX_IDLE;
            beat_cnt <= '0;
        end else if (accept) begin
            case (state)
                RX_IDLE: begin
                    // A beat with tlast here is a complete single-beat packet.
                    if (!s00_axis_tlast) begin
                        state    <= RX_PKT;
                        beat_cnt <= BCW'(1);
                    end
                end
                RX_PKT: begin
                    if (s00_axis_tlast) begin
                        state    <= RX_IDLE;
                        beat_cnt <= '0;
                    end else if (beat_cnt != BCW'(MAX_PKT_WORDS)) begin
                        beat_cnt <= beat_cnt + BCW'(1);
                    end
                end
                default: begin
                    state    <= RX_IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    assign rx_busy = (state == RX_PKT);

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    // The first beat of a packet is always legal (MAX_PKT_WORDS >= 1), so the
    // length check only applies inside RX_PKT: with MAX_PKT_WORDS beats
    // already counted, the incoming one is beyond the limit.
    logic len_violation;
    logic strb_violation;

    assign len_violation  = accept && (state == RX_PKT) &&
                            (beat_cnt == BCW'(MAX_PKT_WORDS));
    assign strb_violation = accept && (s00_axis_tstrb != STRB_FULL);

    // A new violation in the same cycle as err_clr must not be lost, so the
    // set term takes priority over the clear.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            err_len  <= 1'b0;
            err_strb <= 1'b0;
        end else begin
            if (len_violation) begin
                err_len <= 1'b1;
            end else if (err_clr) begin
                err_len <= 1'b0;
            end
            if (strb_violation) begin
                err_strb <= 1'b1;
            end else if (err_clr) begin
                err_strb <= 1'b0;
            end
        end
    end

    // Every counted packet owns at least one buffered word.
    a_pkt_le_occ : assert property (
        @(posedge s00_axis_aclk) disable iff (s00_axis_areset)
        pkt_count <= fifo_occ
    );

endmodule

// File: tb/tb_axi_stream_slave_rx.sv
module tb_axi_stream_slave_rx;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int MAXW  = 16;

    logic          clk = 1'b0;
    logic          areset;
    logic          tvalid;
    logic [W-1:0]  tdata;
    logic [3:0]    tstrb;
    logic          tlast;
    logic          tready;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          rd_last;
    logic          rd_ready;
    logic [4:0]    pkt_count;
    logic          rx_busy;
    logic          err_strb;
    logic          err_len;
    logic          err_clr;

    always #5 clk = ~clk;

    axi_stream_slave_rx #(
        .C_S_AXIS_TDATA_WIDTH (W),
        .FIFO_DEPTH           (DEPTH),
        .MAX_PKT_WORDS        (MAXW)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (areset),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tdata  (tdata),
        .s00_axis_tstrb  (tstrb),
        .s00_axis_tlast  (tlast),
        .s00_axis_tready (tready),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .rd_last         (rd_last),
        .rd_ready        (rd_ready),
        .pkt_count       (pkt_count),
        .rx_busy         (rx_busy),
        .err_strb        (err_strb),
        .err_len         (err_len),
        .err_clr         (err_clr)
    );

    // Reference model: the buffer is a queue of {last, data}; packet state is
    // the number of beats received since the last TLAST.
    logic [W:0] mq[$];
    int         beats_in_pkt = 0;
    bit         m_err_len    = 1'b0;
    bit         m_err_strb   = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int m_pkts();
        int c = 0;
        foreach (mq[i]) if (mq[i][W]) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model across the edge. dut_acc reports whether the
    // DUT's tready allowed the beat.
    task automatic step(input bit v, input logic [W-1:0] d, input logic [3:0] s,
                        input bit l, input bit rr, input bit clr, output bit dut_acc);
        bit m_acc, m_pop, set_len, set_strb;
        @(negedge clk);
        tvalid = v; tdata = d; tstrb = s; tlast = l; rd_ready = rr; err_clr = clr;
        #1;
        chk("tready",    tready,    mq.size() != DEPTH);
        chk("rd_valid",  rd_valid,  mq.size() != 0);
        chk("pkt_count", pkt_count, m_pkts());
        chk("rx_busy",   rx_busy,   beats_in_pkt > 0);
        chk("err_len",   err_len,   m_err_len);
        chk("err_strb",  err_strb,  m_err_strb);
        if (mq.size() != 0) begin
            chk("rd_data", rd_data, mq[0][W-1:0]);
            chk("rd_last", rd_last, mq[0][W]);
        end else begin
            chk("rd_last_empty", rd_last, 0);
        end
        dut_acc = v && tready;
        m_acc   = v && (mq.size() != DEPTH);
        m_pop   = rr && (mq.size() != 0);
        @(posedge clk);
        if (m_pop) void'(mq.pop_front());
        set_len  = 1'b0;
        set_strb = 1'b0;
        if (m_acc) begin
            mq.push_back({l, d});
            beats_in_pkt++;
            set_len  = (beats_in_pkt > MAXW);
            set_strb = (s != 4'hF);
            if (l) beats_in_pkt = 0;
        end
        m_err_len  = set_len  ? 1'b1 : (clr ? 1'b0 : m_err_len);
        m_err_strb = set_strb ? 1'b1 : (clr ? 1'b0 : m_err_strb);
    endtask

    task automatic idle(input bit rr, input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, '0, 4'hF, 0, rr, 0, a);
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 40 && mq.size() != 0; i++) step(0, '0, 4'hF, 0, 1, 0, a);
        chk("drain_done", mq.size(), 0);
        step(0, '0, 4'hF, 0, 0, 0, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        tvalid = 0; tlast = 0; rd_ready = 0; err_clr = 0;
        areset = 1'b1;
        #1;
        chk("rst_rd_valid", rd_valid,  0);
        chk("rst_tready",   tready,    1);
        chk("rst_pkt",      pkt_count, 0);
        chk("rst_busy",     rx_busy,   0);
        chk("rst_rd_last",  rd_last,   0);
        chk("rst_err_len",  err_len,   0);
        chk("rst_err_strb", err_strb,  0);
        mq.delete();
        beats_in_pkt = 0;
        m_err_len    = 1'b0;
        m_err_strb   = 1'b0;
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        bit a;
        int i;
        areset = 1'b1; tvalid = 0; tdata = '0; tstrb = 4'hF; tlast = 0;
        rd_ready = 0; err_clr = 0;
        do_reset();
        idle(0, 2);

        // 4-beat packet A0..A3 with the reader always ready
        for (int k = 0; k < 4; k++) step(1, 32'hA0 + k, 4'hF, k == 3, 1, 0, a);
        idle(1, 3);

        // Fill to 16, hold beat 17, one pop, then the 17th goes in.
        // The 17-beat packet also exceeds MAX_PKT_WORDS.
        i = 0;
        for (int c = 0; c < 40 && i < 16; c++) begin
            step(1, 32'hB00 + i, 4'hF, 0, 0, 0, a);
            if (a) i++;
        end
        for (int c = 0; c < 3; c++) begin
            step(1, 32'hB10, 4'hF, 1, 0, 0, a);
            chk("full_hold", a, 0);
        end
        step(1, 32'hB10, 4'hF, 1, 1, 0, a);
        chk("full_pop_no_acc", a, 0);
        step(1, 32'hB10, 4'hF, 1, 0, 0, a);
        chk("refill_acc", a, 1);
        drain();
        chk("err_len_set", err_len, 1);

        // Partial strobe, then set-wins-over-clear, then a plain clear
        step(1, 32'hC0, 4'h7, 1, 1, 0, a);
        step(1, 32'hC1, 4'h3, 1, 1, 1, a);
        idle(1, 1);
        chk("err_strb_hold", err_strb, 1);
        step(0, '0, 4'hF, 0, 1, 1, a);
        idle(1, 1);
        chk("err_cleared", {err_len, err_strb}, 0);

        // Three single-beat packets, nothing read
        for (int k = 0; k < 3; k++) step(1, 32'hD0 + k, 4'hF, 1, 0, 0, a);
        idle(0, 2);
        chk("three_pkts", pkt_count, 3);
        drain();

        // 64 beats at full rate on both sides, random TLAST
        for (int k = 0; k < 64; k++) begin
            step(1, $urandom, 4'hF, 1'($urandom_range(0, 1)), 1, 0, a);
            chk("thruput", a, 1);
        end
        drain();

        // Random valid / ready / strobe / clear traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) < 7, $urandom,
                 ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 30) == 0, a);
        end
        drain();

        // Reset with five words of an open packet buffered
        for (int k = 0; k < 5; k++) step(1, 32'hE0 + k, 4'hF, 0, 0, 0, a);
        do_reset();
        idle(0, 1);
        for (int k = 0; k < 3; k++) step(1, 32'hF0 + k, 4'hF, k == 2, 1, 0, a);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
